// File: rtl/raster_timing_pkg.sv
// Shared raster timing constants, state encodings and per-axis boundary helpers.
package raster_timing_pkg;

    localparam int CNT_W   = 13;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // 1280x800 CVT reduced-blanking defaults.
    localparam int DEF_H_ACTIVE   = 1280;
    localparam int DEF_H_FP       = 48;
    localparam int DEF_H_SYNC     = 32;
    localparam int DEF_H_BP       = 80;
    localparam int DEF_V_ACTIVE   = 800;
    localparam int DEF_V_FP       = 3;
    localparam int DEF_V_SYNC     = 6;
    localparam int DEF_V_BP       = 14;
    localparam int DEF_HSYNC_POL  = 1;
    localparam int DEF_VSYNC_POL  = 0;
    localparam int DEF_PIPE_DELAY = 1;

    typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC, H_BACK} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC, V_BACK} v_state_t;

    // Axis-neutral encoding used by the shared counter; same order as above.
    typedef enum logic [1:0] {AX_ACT, AX_FRONT, AX_SYNC, AX_BACK} axis_state_t;

    // Last count value of each region along one axis.
    typedef struct packed {
        cnt_t act_last;
        cnt_t front_last;
        cnt_t sync_last;
        cnt_t total_last;
    } axis_bounds_t;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync_w, input int bp);
        return active + fp + sync_w + bp;
    endfunction

    function automatic axis_bounds_t axis_bounds(input int active, input int fp,
                                                 input int sync_w, input int bp);
        axis_bounds_t b;
        b.act_last   = cnt_t'(active - 1);
        b.front_last = cnt_t'(active + fp - 1);
        b.sync_last  = cnt_t'(active + fp + sync_w - 1);
        b.total_last = cnt_t'(axis_total(active, fp, sync_w, bp) - 1);
        return b;
    endfunction

    // Region a count value falls in; tolerant of zero-width porches.
    function automatic axis_state_t axis_region(input cnt_t c, input axis_bounds_t b);
        if (c <= b.act_last)   return AX_ACT;
        if (c <= b.front_last) return AX_FRONT;
        if (c <= b.sync_last)  return AX_SYNC;
        return AX_BACK;
    endfunction

    function automatic h_state_t to_h_state(input axis_state_t s);
        case (s)
            AX_FRONT: return H_FRONT;
            AX_SYNC:  return H_SYNC;
            AX_BACK:  return H_BACK;
            default:  return H_ACT;
        endcase
    endfunction

    function automatic v_state_t to_v_state(input axis_state_t s);
        case (s)
            AX_FRONT: return V_FRONT;
            AX_SYNC:  return V_SYNC;
            AX_BACK:  return V_BACK;
            default:  return V_ACT;
        endcase
    endfunction

endpackage

// File: rtl/raster_axis_counter.sv
// One raster axis: position counter plus region FSM, advancing only when step is high.
module raster_axis_counter
    import raster_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC_W = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             rst,
    input  logic             raster_clk,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output axis_state_t      state,
    output logic             wrap
);

    localparam axis_bounds_t BOUNDS = axis_bounds(ACTIVE, FP, SYNC_W, BP);

    logic [CNT_W-1:0] count_next;

    // wrap marks the last position of the axis; the next step returns to 0.
    assign wrap       = (count == BOUNDS.total_last);
    assign count_next = wrap ? '0 : count + cnt_t'(1);

    // Advance position and region together so state always describes count.
    always_ff @(posedge raster_clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            state <= AX_ACT;
        end else if (step) begin
            count <= count_next;
            state <= axis_region(count_next, BOUNDS);
        end
    end

endmodule

// File: rtl/raster_timing_gen.sv
// Raster timing generator: registered coordinates/strobes for render stages and
// polarity-corrected, delay-matched sync/DE for the physical video port.
module raster_timing_gen #(
    parameter int H_ACTIVE   = raster_timing_pkg::DEF_H_ACTIVE,
    parameter int H_FP       = raster_timing_pkg::DEF_H_FP,
    parameter int H_SYNC     = raster_timing_pkg::DEF_H_SYNC,
    parameter int H_BP       = raster_timing_pkg::DEF_H_BP,
    parameter int V_ACTIVE   = raster_timing_pkg::DEF_V_ACTIVE,
    parameter int V_FP       = raster_timing_pkg::DEF_V_FP,
    parameter int V_SYNC     = raster_timing_pkg::DEF_V_SYNC,
    parameter int V_BP       = raster_timing_pkg::DEF_V_BP,
    parameter int HSYNC_POL  = raster_timing_pkg::DEF_HSYNC_POL,
    parameter int VSYNC_POL  = raster_timing_pkg::DEF_VSYNC_POL,
    parameter int PIPE_DELAY = raster_timing_pkg::DEF_PIPE_DELAY
) (
    input  logic        rst,
    input  logic        raster_clk,
    input  logic        en,
    output logic [12:0] raster_x,
    output logic [12:0] raster_y,
    output logic        raster_h_synk,
    output logic        raster_v_synk,
    output logic        raster_de,
    output logic        line_start,
    output logic        frame_start,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_de
);

    if (raster_timing_pkg::axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP) > raster_timing_pkg::CNT_MAX) begin : g_h_total_check
        $error("raster_timing_gen: H_TOTAL exceeds 8191");
    end
    if (raster_timing_pkg::axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP) > raster_timing_pkg::CNT_MAX) begin : g_v_total_check
        $error("raster_timing_gen: V_TOTAL exceeds 8191");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_pipe_check
        $error("raster_timing_gen: PIPE_DELAY must be 0..15");
    end

    localparam logic H_INV = (HSYNC_POL == 0);
    localparam logic V_INV = (VSYNC_POL == 0);

    logic [12:0]                    h_cnt;
    logic [12:0]                    v_cnt;
    raster_timing_pkg::axis_state_t h_ax;
    raster_timing_pkg::axis_state_t v_ax;
    raster_timing_pkg::h_state_t    h_state;
    raster_timing_pkg::v_state_t    v_state;
    logic                           h_wrap;
    logic                           v_wrap;
    logic                           v_step;
    logic                           at_origin;
    logic [2:0]                     tap;

    assign v_step  = en & h_wrap;
    assign h_state = raster_timing_pkg::to_h_state(h_ax);
    assign v_state = raster_timing_pkg::to_v_state(v_ax);

    raster_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC_W (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .rst        (rst),
        .raster_clk (raster_clk),
        .step       (en),
        .count      (h_cnt),
        .state      (h_ax),
        .wrap       (h_wrap)
    );

    raster_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC_W (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .rst        (rst),
        .raster_clk (raster_clk),
        .step       (v_step),
        .count      (v_cnt),
        .state      (v_ax),
        .wrap       (v_wrap)
    );

    // Track whether the counters sit on pixel (0,0): true out of reset and after a full-frame wrap.
    always_ff @(posedge raster_clk or posedge rst) begin
        if (rst) begin
            at_origin <= 1'b1;
        end else if (en) begin
            at_origin <= h_wrap & v_wrap;
        end
    end

    // Register the current pixel's description; while paused, pulses and DE drop and the rest holds.
    always_ff @(posedge raster_clk or posedge rst) begin
        if (rst) begin
            raster_x      <= '0;
            raster_y      <= '0;
            raster_h_synk <= 1'b0;
            raster_v_synk <= 1'b0;
            raster_de     <= 1'b0;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
        end else if (en) begin
            raster_x      <= h_cnt;
            raster_y      <= v_cnt;
            raster_h_synk <= (h_state == raster_timing_pkg::H_SYNC);
            raster_v_synk <= (v_state == raster_timing_pkg::V_SYNC);
            raster_de     <= (h_state == raster_timing_pkg::H_ACT) && (v_state == raster_timing_pkg::V_ACT);
            line_start    <= (h_cnt == '0);
            frame_start   <= at_origin;
        end else begin
            raster_de     <= 1'b0;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
        end
    end

    // Delay line carries active-high {hsync, vsync, de}; polarity is applied only at the pins.
    if (PIPE_DELAY == 0) begin : g_bypass
        assign tap = {raster_h_synk, raster_v_synk, raster_de};
    end else begin : g_pipe
        logic [2:0] stage [PIPE_DELAY];

        // Shift every clock, independent of en, so the port stays aligned with render data.
        always_ff @(posedge raster_clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < PIPE_DELAY; i++) stage[i] <= '0;
            end else begin
                stage[0] <= {raster_h_synk, raster_v_synk, raster_de};
                for (int i = 1; i < PIPE_DELAY; i++) stage[i] <= stage[i-1];
            end
        end

        assign tap = stage[PIPE_DELAY-1];
    end

    assign out_hsync = tap[2] ^ H_INV;
    assign out_vsync = tap[1] ^ V_INV;
    assign out_de    = tap[0];

endmodule

// File: tb/tb_raster_timing_gen.sv
// Directed bench for raster_timing_gen: default 1280x800 timing for line-level checks,
// a small 25x10 raster for whole-frame and reset checks, and a zero-delay inverted-hsync copy.
module tb_raster_timing_gen;

    // Clock and reset
    logic raster_clk = 1'b0;
    logic rst;
    logic en_d;
    logic en_s;

    always #5 raster_clk = ~raster_clk;

    // Default-timing instance
    logic [12:0] x_d, y_d;
    logic hs_d, vs_d, de_d, ls_d, fs_d, ohs_d, ovs_d, ode_d;
    // Small-timing instance, PIPE_DELAY=1
    logic [12:0] x_s, y_s;
    logic hs_s, vs_s, de_s, ls_s, fs_s, ohs_s, ovs_s, ode_s;
    // Small-timing instance, PIPE_DELAY=0, HSYNC_POL=0
    logic [12:0] x_z, y_z;
    logic hs_z, vs_z, de_z, ls_z, fs_z, ohs_z, ovs_z, ode_z;

    raster_timing_gen dut_d (
        .rst (rst), .raster_clk (raster_clk), .en (en_d),
        .raster_x (x_d), .raster_y (y_d), .raster_h_synk (hs_d), .raster_v_synk (vs_d),
        .raster_de (de_d), .line_start (ls_d), .frame_start (fs_d),
        .out_hsync (ohs_d), .out_vsync (ovs_d), .out_de (ode_d)
    );

    raster_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut_s (
        .rst (rst), .raster_clk (raster_clk), .en (en_s),
        .raster_x (x_s), .raster_y (y_s), .raster_h_synk (hs_s), .raster_v_synk (vs_s),
        .raster_de (de_s), .line_start (ls_s), .frame_start (fs_s),
        .out_hsync (ohs_s), .out_vsync (ovs_s), .out_de (ode_s)
    );

    raster_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HSYNC_POL (0), .PIPE_DELAY (0)
    ) dut_z (
        .rst (rst), .raster_clk (raster_clk), .en (en_s),
        .raster_x (x_z), .raster_y (y_z), .raster_h_synk (hs_z), .raster_v_synk (vs_z),
        .raster_de (de_z), .line_start (ls_z), .frame_start (fs_z),
        .out_hsync (ohs_z), .out_vsync (ovs_z), .out_de (ode_z)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Driver: advance to just after the next rising edge.
    task automatic tick();
        @(posedge raster_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int de_cnt, de_last, hs_first, hs_last, hs_cnt, ohs_first, ovl, ls_cnt, x_err, hold_err, found;
        int fs_cnt, vs_cnt, vs_min, vs_max, hs_cnt_s, de_cnt_s, de_late, zmis;

        // Reset values
        rst  = 1'b1;
        en_d = 1'b0;
        en_s = 1'b0;
        repeat (3) tick();
        check("rst_x", 32'(x_d), 0);
        check("rst_y", 32'(y_d), 0);
        check("rst_de", 32'(de_d), 0);
        check("rst_fs", 32'(fs_d), 0);
        check("rst_hs", 32'(hs_d), 0);
        check("rst_out_hsync", 32'(ohs_d), 0);
        check("rst_out_vsync", 32'(ovs_d), 1);
        check("rst_out_de", 32'(ode_d), 0);
        check("rst_z_out_hsync", 32'(ohs_z), 1);
        check("rst_z_out_vsync", 32'(ovs_z), 1);

        // First enabled edge
        rst  = 1'b0;
        en_d = 1'b1;
        en_s = 1'b1;
        tick();
        check("first_x", 32'(x_d), 0);
        check("first_y", 32'(y_d), 0);
        check("first_de", 32'(de_d), 1);
        check("first_fs", 32'(fs_d), 1);
        check("first_ls", 32'(ls_d), 1);
        check("first_out_de", 32'(ode_d), 0);
        check("first_out_vsync", 32'(ovs_d), 1);
        check("first_z_out_de", 32'(ode_z), 1);
        check("first_z_out_hsync", 32'(ohs_z), 1);
        check("first_s_fs", 32'(fs_s), 1);

        // Line 0 of the default raster
        de_cnt = 0; de_last = -1; hs_first = -1; hs_last = -1; hs_cnt = 0;
        ohs_first = -1; ovl = 0; ls_cnt = 0; x_err = 0;
        for (int k = 0; k < 1440; k++) begin
            if (k > 0) tick();
            if (k == 1) begin
                check("pipe_de_rise", 32'(ode_d), 1);
                check("fs_one_clock", 32'(fs_d), 0);
            end
            if (int'(x_d) != k || y_d != 13'd0 || vs_d) x_err++;
            if (de_d) begin de_cnt++; de_last = k; end
            if (hs_d) begin
                if (hs_first < 0) hs_first = k;
                hs_last = k;
                hs_cnt++;
            end
            if (ohs_d && ohs_first < 0) ohs_first = k;
            if (hs_d && de_d) ovl++;
            if (ls_d) ls_cnt++;
        end
        check("l0_x_seq", x_err, 0);
        check("l0_de_cnt", de_cnt, 1280);
        check("l0_de_last", de_last, 1279);
        check("l0_hs_first", hs_first, 1328);
        check("l0_hs_last", hs_last, 1359);
        check("l0_hs_cnt", hs_cnt, 32);
        check("l0_out_hs_first", ohs_first, 1329);
        check("l0_sync_de_overlap", ovl, 0);
        check("l0_ls_cnt", ls_cnt, 1);
        tick();
        check("l1_ls_period", 32'(ls_d), 1);
        check("l1_x", 32'(x_d), 0);
        check("l1_y", 32'(y_d), 1);

        // Pause at x=500, y=10
        repeat (9 * 1440) tick();
        de_cnt = 0;
        for (int k = 0; k <= 500; k++) begin
            if (k > 0) tick();
            if (de_d) de_cnt++;
        end
        check("pause_at_x", 32'(x_d), 500);
        check("pause_at_y", 32'(y_d), 10);
        en_d = 1'b0;
        hold_err = 0;
        for (int h = 0; h < 100; h++) begin
            tick();
            if (h == 0) check("hold_pipe_de_1", 32'(ode_d), 1);
            if (h == 1) check("hold_pipe_de_0", 32'(ode_d), 0);
            if (int'(x_d) != 500 || int'(y_d) != 10 || de_d || ls_d || fs_d) hold_err++;
        end
        check("hold_xy_de", hold_err, 0);
        en_d = 1'b1;
        tick();
        check("resume_x", 32'(x_d), 501);
        check("resume_de", 32'(de_d), 1);
        if (de_d) de_cnt++;
        x_err = 0;
        for (int k = 502; k < 1440; k++) begin
            tick();
            if (int'(x_d) != k) x_err++;
            if (de_d) de_cnt++;
        end
        check("l10_x_seq", x_err, 0);
        check("l10_de_cnt", de_cnt, 1280);
        tick();
        check("l11_y", 32'(y_d), 11);
        check("l11_ls", 32'(ls_d), 1);

        // Small raster: find a frame start, then scan one whole frame
        found = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (fs_s) begin found = 1; break; end
        end
        check("s_fs_found", found, 1);
        fs_cnt = 0; vs_cnt = 0; vs_min = 9999; vs_max = -1;
        hs_cnt_s = 0; de_cnt_s = 0; de_late = 0; zmis = 0;
        for (int k = 0; k < 250; k++) begin
            if (k > 0) tick();
            if (fs_s) fs_cnt++;
            if (vs_s) begin
                vs_cnt++;
                if (int'(y_s) < vs_min) vs_min = int'(y_s);
                if (int'(y_s) > vs_max) vs_max = int'(y_s);
            end
            if (hs_s) hs_cnt_s++;
            if (de_s) begin
                de_cnt_s++;
                if (y_s >= 13'd6) de_late++;
            end
            if (ohs_z !== !hs_z || ovs_z !== !vs_z || ode_z !== de_z ||
                x_z !== x_s || y_z !== y_s || fs_z !== fs_s || ls_z !== ls_s) zmis++;
        end
        check("s_fs_cnt", fs_cnt, 1);
        check("s_vs_cnt", vs_cnt, 50);
        check("s_vs_first_line", vs_min, 7);
        check("s_vs_last_line", vs_max, 8);
        check("s_hs_cnt", hs_cnt_s, 30);
        check("s_de_cnt", de_cnt_s, 96);
        check("s_de_blank_lines", de_late, 0);
        check("z_passthrough", zmis, 0);
        tick();
        check("s_fs_period", 32'(fs_s), 1);
        check("s_wrap_x", 32'(x_s), 0);
        check("s_wrap_y", 32'(y_s), 0);

        // Asynchronous reset mid-frame at x=9, y=4
        repeat (109) tick();
        check("s_pre_rst_x", 32'(x_s), 9);
        check("s_pre_rst_y", 32'(y_s), 4);
        check("s_pre_rst_out_de", 32'(ode_s), 1);
        #1 rst = 1'b1;
        #1;
        check("arst_x", 32'(x_s), 0);
        check("arst_y", 32'(y_s), 0);
        check("arst_de", 32'(de_s), 0);
        check("arst_out_de", 32'(ode_s), 0);
        check("arst_out_vsync", 32'(ovs_s), 1);
        check("arst_out_hsync", 32'(ohs_s), 0);
        check("arst_d_x", 32'(x_d), 0);
        repeat (2) tick();
        check("rst_hold_x", 32'(x_s), 0);
        rst = 1'b0;
        tick();
        check("post_rst_fs", 32'(fs_s), 1);
        check("post_rst_ls", 32'(ls_s), 1);
        check("post_rst_x", 32'(x_s), 0);
        check("post_rst_y", 32'(y_s), 0);
        check("post_rst_de", 32'(de_s), 1);
        check("post_rst_d_fs", 32'(fs_d), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/raster_timing_gen.md
Name: raster_timing_gen

Overview:
- Generates raster scan timing on raster_clk for the display pipeline.
- Outputs: pixel coordinates, active-high sync strobes, data-enable and frame/line markers, which feed the render stages (the SSD1306 OLED emulator and similar overlays).
- Also outputs polarity-corrected sync/DE for the physical video port, delayed by a fixed pipeline depth so they align with registered render data.
- Defaults are 1280x800 CVT reduced-blanking timing.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 32, horizontal sync width (clocks)
- H_BP, 80, horizontal back porch (clocks)
- V_ACTIVE, 800, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 14, vertical back porch (lines)
- HSYNC_POL, 1, out_hsync active level (1 = active-high)
- VSYNC_POL, 0, out_vsync active level
- PIPE_DELAY, 1, clocks of delay on out_* relative to raster outputs (0..15)

Ports:
- rst  in  1  asynchronous reset, active-high
- raster_clk  in  1  pixel clock
- en  in  1  timing run enable
- raster_x  out  13  horizontal counter (pixel x while active)
- raster_y  out  13  vertical counter (line y while active)
- raster_h_synk  out  1  active-high during horizontal sync
- raster_v_synk  out  1  active-high during vertical sync lines
- raster_de  out  1  high in active area
- line_start  out  1  one-clock pulse at x=0
- frame_start  out  1  one-clock pulse at x=0, y=0
- out_hsync  out  1  delayed, polarity-applied hsync
- out_vsync  out  1  delayed, polarity-applied vsync
- out_de  out  1  delayed DE

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1440); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 823). Both must be ≤ 8191; elaboration error otherwise.
- Horizontal FSM states: H_ACT, H_FRONT, H_SYNC, H_BACK.
  - H_ACT covers h_cnt 0..H_ACTIVE-1.
  - H_FRONT runs up to H_ACTIVE+H_FP-1.
  - H_SYNC runs up to H_ACTIVE+H_FP+H_SYNC-1.
  - H_BACK runs up to H_TOTAL-1, then returns to H_ACT.
- Vertical FSM states: V_ACT, V_FRONT, V_SYNC, V_BACK, with identical boundaries on v_cnt. The vertical FSM advances only on the horizontal wrap (h_cnt = H_TOTAL-1).
- Simultaneous wrap: at h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, both counters go to 0 on the same edge.
- All raster_* outputs, line_start and frame_start are registered and mutually coherent: they describe the same pixel in the same cycle.
  - raster_x = h_cnt; raster_y = v_cnt.
  - raster_de = H_ACT & V_ACT.
  - raster_h_synk = H_SYNC state, on every line including vertical blanking.
  - raster_v_synk = V_SYNC state, for the whole line duration.
- Consumers reset their x counters on raster_h_synk. Sync windows never overlap raster_de.
- en low:
  - h_cnt, v_cnt and both FSMs hold.
  - raster_de, line_start and frame_start are forced 0.
  - Sync levels hold their current value.
  - Resuming continues from the held position with no skipped pixel.
- Reset values: counters 0, FSMs in H_ACT/V_ACT, all raster_* outputs and pulses 0, out_de 0, out_hsync = ~HSYNC_POL, out_vsync = ~VSYNC_POL. The pipeline delay registers reset to these same inactive values.
- First enabled edge after reset: raster_de = 1, x = 0, y = 0, frame_start = 1.
- out_* pipeline:
  - PIPE_DELAY-deep shift register of {hsync, vsync, de}, with polarity XOR applied at the output.
  - PIPE_DELAY = 0 gives same-cycle pass-through.
  - The pipeline shifts every clock regardless of en.
- Reset mid-frame takes effect immediately (asynchronous). No partial-line state survives.

Decomposition:
- Shared package raster_timing_pkg holds:
  - default timing constants for 1280x800;
  - the enums for the H and V state encodings;
  - a function computing totals and boundaries.
- One sub-module, raster_axis_counter (count, state FSM, wrap output, step input), instantiated twice:
  - horizontal: step = en;
  - vertical: step = en & h_wrap.

Test Plan:
- Reset, then release with en=1 → first edge x=0, y=0, de=1, frame_start=1; out_de rises exactly PIPE_DELAY (1) clocks later; out_vsync was 1 during reset (VSYNC_POL=0).
- Line 0 monitor → de high for exactly 1280 clocks (x 0..1279); h_synk high for clocks 1328..1359; line_start period 1440 clocks.
- Full frame → frame_start period 1,185,120 clocks; v_synk high for lines 803..808 inclusive; de low on every line ≥ 800.
- en low for 100 clocks at x=500, y=10 → x/y hold, de=0 throughout; on resume, next pixel is x=501 with no gap in the de count for that line.
- Assert rst at x=900, y=400 → outputs reach reset values asynchronously; after release, frame_start fires on the first enabled edge.
- PIPE_DELAY=0, HSYNC_POL=0 → out_hsync is the inverse of raster_h_synk in the same cycle; out_de equals raster_de.
